// File: rtl/kv_request_scheduler.sv
// Two-requester round-robin scheduler that serializes operations into the cuckoo-hash KV store.
// Optional watchdog on the store handshake is enabled with KV_SCHED_TIMEOUT_EN.
module kv_request_scheduler #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int KEY_WIDTH      = 32,
  parameter int VAL_WIDTH      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [1:0]           req0_op,
  input  logic [KEY_WIDTH-1:0] req0_key,
  input  logic [VAL_WIDTH-1:0] req0_value,
  input  logic                 req0_kind,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [1:0]           req1_op,
  input  logic [KEY_WIDTH-1:0] req1_key,
  input  logic [VAL_WIDTH-1:0] req1_value,
  input  logic                 req1_kind,
  output logic                 resp0_valid,
  output logic                 resp1_valid,
  output logic [VAL_WIDTH-1:0] resp_value,
  output logic [VAL_WIDTH-1:0] resp_addr,
  output logic [1:0]           resp_error,
  output logic                 st_valid,
  output logic [1:0]           st_op,
  output logic [KEY_WIDTH-1:0] st_key,
  output logic [VAL_WIDTH-1:0] st_value,
  output logic                 st_kind,
  input  logic                 st_done,
  input  logic [VAL_WIDTH-1:0] st_value_in,
  input  logic [VAL_WIDTH-1:0] st_addr_in,
  input  logic                 st_miss,
  output logic [15:0]          op_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t               state_reg, state_next;
  logic                 last_grant_reg;
  logic                 idx_reg;
  logic [1:0]           op_reg;
  logic [KEY_WIDTH-1:0] key_reg;
  logic [VAL_WIDTH-1:0] value_reg;
  logic                 kind_reg;
  logic [VAL_WIDTH-1:0] resp_value_reg;
  logic [VAL_WIDTH-1:0] resp_addr_reg;
  logic [1:0]           resp_error_reg;
  logic [15:0]          op_count_reg;

  logic [1:0]           req_valid;
  logic [1:0]           req_ready_vec;
  logic [1:0]           resp_valid_vec;
  logic                 grant_idx;
  logic                 accept;
  logic                 reject_in;
  logic                 done_hit;
  logic                 timeout_hit;
  logic [1:0]           in_op;
  logic [KEY_WIDTH-1:0] in_key;
  logic [VAL_WIDTH-1:0] in_value;
  logic                 in_kind;

  assign req_valid = {req1_valid, req0_valid};

  // On a tie the requester that did not win last time takes the grant.
  always_comb begin
    grant_idx = 1'b0;
    if (req_valid == 2'b11)
      grant_idx = ~last_grant_reg;
    else if (req_valid[1])
      grant_idx = 1'b1;
  end

  assign in_op     = grant_idx ? req1_op    : req0_op;
  assign in_key    = grant_idx ? req1_key   : req0_key;
  assign in_value  = grant_idx ? req1_value : req0_value;
  assign in_kind   = grant_idx ? req1_kind  : req0_kind;
  assign accept    = (state_reg == IDLE) && req_valid[grant_idx];
  // Key 0 marks an empty slot in the store, so it can never be inserted.
  assign reject_in = (in_op == 2'd3) || ((in_op == 2'd1) && (in_key == '0));
  assign done_hit  = (state_reg == WAIT) && st_done;

`ifdef KV_SCHED_TIMEOUT_EN
  logic [15:0] wait_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset || state_reg != WAIT)
      wait_cnt_reg <= '0;
    else
      wait_cnt_reg <= wait_cnt_reg + 16'd1;
  end

  // A store completion in the expiry cycle takes precedence.
  assign timeout_hit = (state_reg == WAIT) && !st_done &&
                       (wait_cnt_reg == 16'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out: WAIT is left only on st_done.
  assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = reject_in ? RESP : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (done_hit || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_vec  = '0;
    resp_valid_vec = '0;
    st_valid       = 1'b0;
    case (state_reg)
      IDLE:    req_ready_vec[grant_idx] = req_valid[grant_idx];
      ISSUE:   st_valid = 1'b1;
      RESP:    resp_valid_vec[idx_reg] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
      idx_reg        <= 1'b0;
      op_reg         <= '0;
      key_reg        <= '0;
      value_reg      <= '0;
      kind_reg       <= 1'b0;
      resp_value_reg <= '0;
      resp_addr_reg  <= '0;
      resp_error_reg <= '0;
      op_count_reg   <= '0;
    end else begin
      if (accept) begin
        last_grant_reg <= grant_idx;
        idx_reg        <= grant_idx;
        op_reg         <= in_op;
        key_reg        <= in_key;
        value_reg      <= in_value;
        kind_reg       <= in_kind;
        if (reject_in) begin
          resp_value_reg <= '0;
          resp_addr_reg  <= '0;
          resp_error_reg <= 2'd1;
        end
      end
      if (done_hit) begin
        resp_value_reg <= st_value_in;
        resp_addr_reg  <= st_addr_in;
        resp_error_reg <= st_miss ? 2'd2 : 2'd0;
      end else if (timeout_hit) begin
        resp_value_reg <= '0;
        resp_addr_reg  <= '0;
        resp_error_reg <= 2'd3;
      end
      if (state_reg == RESP)
        op_count_reg <= op_count_reg + 16'd1;
    end
  end

  assign req0_ready  = req_ready_vec[0];
  assign req1_ready  = req_ready_vec[1];
  assign resp0_valid = resp_valid_vec[0];
  assign resp1_valid = resp_valid_vec[1];
  assign resp_value  = resp_value_reg;
  assign resp_addr   = resp_addr_reg;
  assign resp_error  = resp_error_reg;
  assign st_op       = op_reg;
  assign st_key      = key_reg;
  assign st_value    = value_reg;
  assign st_kind     = kind_reg;
  assign op_count    = op_count_reg;

endmodule

// File: doc/kv_request_scheduler.md
# kv_request_scheduler

Two-port request scheduler that sits in front of the cuckoo-hash key/value store and serializes search, insert and transact operations into it. It arbitrates round-robin between two requesters and drives the store one operation at a time over a valid/done handshake. It captures the store result and returns it to the winning requester, with illegal-operation rejection and an optional watchdog timeout.

## Interface
- TIMEOUT_CYCLES, 64: WAIT-state cycles before abort; used only with KV_SCHED_TIMEOUT_EN; legal range 1..65535.
- KEY_WIDTH, 32: key width.
- VAL_WIDTH, 32: value, transact value and address width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- reqN_valid  in  1  requester N (N = 0, 1) has an operation.
- reqN_ready  out  1  scheduler accepts requester N this cycle.
- reqN_op  in  2  operation: 0 = search, 1 = insert, 2 = transact, 3 = illegal.
- reqN_key  in  KEY_WIDTH  key.
- reqN_value  in  VAL_WIDTH  insert value or transact amount.
- reqN_kind  in  1  transact kind: 1 = add, 0 = subtract.
- respN_valid  out  1  one-cycle pulse carrying the response to requester N.
- resp_value  out  VAL_WIDTH  updated or looked-up value.
- resp_addr  out  VAL_WIDTH  value-table address returned by the store.
- resp_error  out  2  0 = ok, 1 = illegal or reserved key, 2 = store miss, 3 = timeout.
- st_valid  out  1  one-cycle pulse that issues an operation to the store.
- st_op  out  2  operation sent to the store.
- st_key  out  KEY_WIDTH  key sent to the store.
- st_value  out  VAL_WIDTH  value sent to the store.
- st_kind  out  1  transact kind sent to the store.
- st_done  in  1  store has completed; result inputs are valid this cycle.
- st_value_in  in  VAL_WIDTH  store result value.
- st_addr_in  in  VAL_WIDTH  store result address.
- st_miss  in  1  key not found (search or transact).
- op_count  out  16  completed operations, including errors; wraps at 16 bits.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant is combinational.
  - If only one reqN_valid is high, that requester is granted.
  - If both are high, the requester not granted last wins.
  - last_grant resets to 1, so req0 wins the first tie.
- reqN_ready = (state == IDLE) && grant == N. At most one ready is high in any cycle.
- On valid && ready, the scheduler latches op, key, value, kind and the grant index, and updates last_grant.
- Reject path: op == 3, or key == 0 with op == 1 (0 is the store's empty-slot marker). The scheduler goes IDLE -> RESP with resp_error = 1 and never asserts st_valid.
- Otherwise it goes IDLE -> ISSUE.
- ISSUE: st_valid = 1 for exactly one cycle with the latched fields, then -> WAIT.
- WAIT:
  - On st_done, latch st_value_in and st_addr_in; resp_error = 2 if st_miss, else 0; -> RESP.
  - st_done outside WAIT is ignored.
- RESP:
  - respN_valid = 1 for the latched index only.
  - resp_value, resp_addr and resp_error hold their values until the next RESP.
  - op_count increments.
  - -> IDLE.
- st_op, st_key, st_value and st_kind hold their latched values between operations.

## Timing
- Request accepted in cycle T. st_valid asserts in T+1. st_done sampled in cycle D ≥ T+2. respN_valid asserts in D+1. ready can return in D+2.
- Reject path: respN_valid in T+1; next accept possible in T+2.
- Minimum throughput: one operation per 4 cycles when the store returns st_done in the first WAIT cycle.
- Reset:
  - All outputs go to 0; state = IDLE; last_grant = 1; op_count = 0.
  - Reset during WAIT abandons the operation with no response. A late st_done is ignored.
- A requester may drop valid before ready without penalty; nothing is latched.

## Configuration
- KV_SCHED_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without st_done, go -> RESP with resp_error = 3, resp_value = 0, resp_addr = 0.
  - st_done in the same cycle as the expiry wins, giving a normal response.
- Undefined: no counter; WAIT is held until st_done indefinitely.

## Test plan
- Single search: req0 op=0 key=0x1A; store answers after 3 WAIT cycles with value=0x64, addr=5 -> resp0_valid one cycle, resp_value=0x64, resp_addr=5, error=0, op_count=1.
- Tie arbitration: req0 and req1 both valid from reset with back-to-back transacts -> grant order 0,1,0,1; resp1 add kind=1 value=10 on store value 90 -> resp_value=100.
- Reject: req1 op=3, then req1 op=1 key=0 -> two resp1_valid pulses with error=1, st_valid never asserted, op_count=2.
- Miss: req0 op=2 key=0x77, store returns st_done with st_miss -> error=2.
- Timeout (KV_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=8): store silent -> resp0_valid exactly 9 cycles after ISSUE, error=3. Without the macro, no response after 1000 cycles.
- Reset mid-WAIT, then st_done pulse -> no respN_valid, all outputs 0, next request served normally with req0 priority.
